paralelo_serial: RTL

- Byte-to-serial transmit stage that sits directly upstream of the serial_paralelo deserializer on the PCIe-style physical-layer link.
- Accepts bytes through a valid/ready handshake and serializes them MSB-first, one bit per clk_32f cycle.
- Emits a startup train of K28.5 commas (8'hBC) so the receiver can align, then inserts commas as filler whenever no data byte is pending.

---
 rtl/paralelo_serial.sv | 85 ++++++++
 1 files changed

// File: rtl/paralelo_serial.sv
// paralelo_serial: byte-to-serial transmitter with startup comma train and comma filler
// Ports:
//    clk_32f     bit-rate clock
//    reset       synchronous, active-low
//    data_in     parallel byte to transmit
//    valid_in    data_in valid this cycle
//    ready_out   a byte can be accepted this cycle
//    data_out    serial bit stream, MSB first, registered
//    frame_start high while data_out carries bit 7 of a byte
//    data_frame  high for the 8 bit-cycles of a data byte, low for commas
//    sync_done   startup comma train complete
module paralelo_serial #(
   parameter int          MIN_COMMAS = 4,
   parameter logic [7:0]  COMMA      = 8'hBC
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       frame_start,
   output logic       data_frame,
   output logic       sync_done
);
   localparam logic SYNC = 1'b0;
   localparam logic RUN  = 1'b1;
   logic [7:0] shreg;
   logic [2:0] bit_cnt;
   logic [7:0] hold_data;
   logic       hold_valid;
   logic [3:0] comma_cnt;
   logic       state;
   logic       cur_is_data;
   logic       accept;
   logic       last_comma;
   logic       run_next;
   assign ready_out  = ~hold_valid;
   assign accept     = valid_in & ~hold_valid;
   assign last_comma = comma_cnt == 4'(MIN_COMMAS - 1);
   // the boundary that ends the startup train already picks its successor by RUN rules
   assign run_next   = (state == RUN) | last_comma;
   always_ff @(posedge clk_32f) begin
      if (!reset) begin
         shreg       <= COMMA;
         bit_cnt     <= 3'd0;
         comma_cnt   <= 4'd0;
         state       <= SYNC;
         hold_valid  <= 1'b0;
         hold_data   <= 8'd0;
         cur_is_data <= 1'b0;
         data_out    <= 1'b0;
         frame_start <= 1'b0;
         data_frame  <= 1'b0;
         sync_done   <= 1'b0;
      end else begin
         data_out    <= shreg[3'd7 - bit_cnt];
         frame_start <= bit_cnt == 3'd0;
         data_frame  <= cur_is_data;
         bit_cnt     <= bit_cnt + 3'd1;
         // accept only fires with hold empty and load only with hold full, so they never collide
         if (accept) begin
            hold_data  <= data_in;
            hold_valid <= 1'b1;
         end
         if (bit_cnt == 3'd7) begin
            if (state == SYNC) begin
               comma_cnt <= comma_cnt + 4'd1;
               if (last_comma) begin
                  state     <= RUN;
                  sync_done <= 1'b1;
               end
            end
            if (run_next && hold_valid) begin
               shreg       <= hold_data;
               hold_valid  <= 1'b0;
               cur_is_data <= 1'b1;
            end else begin
               shreg       <= COMMA;
               cur_is_data <= 1'b0;
            end
         end
      end
   end
endmodule
